// File: rtl/riscv_pkg.sv
// Shared types for the RV32M multiply/divide sequencer.
//  md_op_e    : funct3 encoding of the M-extension ops
//  md_state_e : sequencer FSM states
//  helpers    : op classification (divide group, remainder, operand signedness)
package riscv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_FINISH,
    MD_DONE
  } md_state_e;

  localparam int unsigned MD_ITER_DEFAULT = 32;

  function automatic logic md_is_div(input md_op_e op);
    return op[2];
  endfunction

  function automatic logic md_is_rem(input md_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic md_a_signed(input md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic md_b_signed(input md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/md_iter_unit.sv
// One combinational step of the iterative multiply/divide loop.
//  is_div     in  1   0: shift-add multiply step, 1: restoring divide step
//  acc_hi     in  32  multiply: product high word / divide: partial remainder
//  acc_lo     in  32  multiply: product low word + remaining multiplier bits
//                     divide: remaining dividend bits, quotient shifted in at LSB
//  operand    in  32  multiplicand / divisor magnitude
//  acc_hi_nxt out 32  accumulator high word after this step
//  acc_lo_nxt out 32  accumulator low word after this step
module md_iter_unit (
  input  logic        is_div,
  input  logic [31:0] acc_hi,
  input  logic [31:0] acc_lo,
  input  logic [31:0] operand,
  output logic [31:0] acc_hi_nxt,
  output logic [31:0] acc_lo_nxt
);

  logic [32:0] sum;
  logic [32:0] shifted;
  logic        fits;
  logic [31:0] diff_lo;

  always_comb begin
    sum     = {1'b0, acc_hi} + {1'b0, operand};
    shifted = {acc_hi, acc_lo[31]};
    fits    = (shifted >= {1'b0, operand});
    // remainder < divisor keeps a successful trial difference below 2^32
    diff_lo = shifted[31:0] - operand;

    acc_hi_nxt = acc_hi;
    acc_lo_nxt = acc_lo;
    if (is_div) begin
      if (fits) begin
        acc_hi_nxt = diff_lo;
        acc_lo_nxt = {acc_lo[30:0], 1'b1};
      end else begin
        acc_hi_nxt = shifted[31:0];
        acc_lo_nxt = {acc_lo[30:0], 1'b0};
      end
    end else begin
      if (acc_lo[0]) begin
        {acc_hi_nxt, acc_lo_nxt} = {sum, acc_lo[31:1]};
      end else begin
        {acc_hi_nxt, acc_lo_nxt} = {1'b0, acc_hi, acc_lo[31:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative RV32M multiply/divide sequencer beside the EX-stage ALU.
// Accepts one M-extension op, runs an MD_ITER-step shift-add / restoring-divide
// loop on operand magnitudes, applies sign fix-up and presents the result.
//  clk        in   1   clock
//  reset_n    in   1   synchronous active-low reset
//  md_en_ex   in   1   EX holds a valid M-extension instruction
//  md_op_ex   in   3   md_op_e operation
//  src_a_ex   in   32  rs1 operand
//  src_b_ex   in   32  rs2 operand
//  flush_E    in   1   kill the EX instruction / abort op in flight
//  ready_mem  in   1   MEM accepts EX output this cycle
//  md_result  out  32  result, valid while md_ready=1
//  md_ready   out  1   registered result-valid flag (DONE only)
//  md_busy    out  1   combinational stall request
module muldiv_ctrl
  import riscv_pkg::*;
#(
  parameter bit          FAST_SPECIAL = 1'b1,
  parameter int unsigned MD_ITER      = MD_ITER_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        md_en_ex,
  input  logic [2:0]  md_op_ex,
  input  logic [31:0] src_a_ex,
  input  logic [31:0] src_b_ex,
  input  logic        flush_E,
  input  logic        ready_mem,
  output logic [31:0] md_result,
  output logic        md_ready,
  output logic        md_busy
);

  localparam int unsigned CW = $clog2(MD_ITER + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MD_ITER - 1);

  md_state_e   state_q, state_d;
  md_op_e      op_q, op_in;
  logic        neg_q, neg_in;
  logic [31:0] acc_hi_q, acc_lo_q, opb_q;
  logic [31:0] iter_hi, iter_lo;
  logic [CW-1:0] cnt_q;

  logic        accept, a_neg, b_neg, b_zero, ovf, special;
  logic [31:0] mag_a, mag_b;
  logic [63:0] prod, prod_fix;
  logic [31:0] div_word, div_fix, res_d;

  // operand conditioning for the op being offered in IDLE
  always_comb begin
    op_in  = md_op_e'(md_op_ex);
    accept = (state_q == MD_IDLE) & md_en_ex & ~flush_E;
    a_neg  = md_a_signed(op_in) & src_a_ex[31];
    b_neg  = md_b_signed(op_in) & src_b_ex[31];
    mag_a  = a_neg ? (32'd0 - src_a_ex) : src_a_ex;
    mag_b  = b_neg ? (32'd0 - src_b_ex) : src_b_ex;
    b_zero = (src_b_ex == '0);
    ovf    = md_is_div(op_in) & ~op_in[0] & (src_a_ex == 32'h8000_0000) & (src_b_ex == '1);
    special = FAST_SPECIAL & md_is_div(op_in) & (b_zero | ovf);
    // divide-by-zero quotient must stay all-ones regardless of dividend sign
    neg_in = md_is_rem(op_in) ? a_neg
                              : ((a_neg ^ b_neg) & ~(md_is_div(op_in) & b_zero));
  end

  md_iter_unit u_iter (
    .is_div     (md_is_div(op_q)),
    .acc_hi     (acc_hi_q),
    .acc_lo     (acc_lo_q),
    .operand    (opb_q),
    .acc_hi_nxt (iter_hi),
    .acc_lo_nxt (iter_lo)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MD_IDLE:   if (accept) state_d = special ? MD_FINISH : MD_CALC;
      MD_CALC:   if (cnt_q == CNT_LAST) state_d = MD_FINISH;
      MD_FINISH: state_d = MD_DONE;
      MD_DONE:   if (ready_mem) state_d = MD_IDLE;
      default:   state_d = MD_IDLE;
    endcase
    if (flush_E) state_d = MD_IDLE;
  end

  always_comb begin
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = neg_q ? (64'd0 - prod) : prod;
    div_word = md_is_rem(op_q) ? acc_hi_q : acc_lo_q;
    div_fix  = neg_q ? (32'd0 - div_word) : div_word;
    if (md_is_div(op_q))     res_d = div_fix;
    else if (op_q == MD_MUL) res_d = prod_fix[31:0];
    else                     res_d = prod_fix[63:32];
  end

  assign md_busy = md_en_ex & ~md_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= MD_IDLE;
      op_q      <= MD_MUL;
      neg_q     <= 1'b0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      md_result <= '0;
      md_ready  <= 1'b0;
    end else begin
      state_q  <= state_d;
      md_ready <= (state_d == MD_DONE);
      if (accept) begin
        op_q  <= op_in;
        neg_q <= neg_in;
        opb_q <= mag_b;
        cnt_q <= '0;
        // fast divide-by-zero preloads what the loop would have produced:
        // quotient all-ones, remainder equal to the dividend magnitude
        if (special && b_zero) begin
          acc_hi_q <= mag_a;
          acc_lo_q <= '1;
        end else begin
          acc_hi_q <= '0;
          acc_lo_q <= mag_a;
        end
      end else if (state_q == MD_CALC) begin
        acc_hi_q <= iter_hi;
        acc_lo_q <= iter_lo;
        cnt_q    <= cnt_q + CW'(1);
      end
      if (state_q == MD_FINISH && !flush_E) md_result <= res_d;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, md_en_ex, flush_E, ready_mem;
  logic [2:0]  md_op_ex;
  logic [31:0] src_a_ex, src_b_ex;
  logic [31:0] md_result;
  logic        md_ready, md_busy;

  always #5 clk = ~clk;

  muldiv_ctrl #(.FAST_SPECIAL(1'b1), .MD_ITER(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .md_en_ex  (md_en_ex),
    .md_op_ex  (md_op_ex),
    .src_a_ex  (src_a_ex),
    .src_b_ex  (src_b_ex),
    .flush_E   (flush_E),
    .ready_mem (ready_mem),
    .md_result (md_result),
    .md_ready  (md_ready),
    .md_busy   (md_busy)
  );

  // expectation state written by the driver, consumed by the compare process
  logic        check_en, exp_ready, lit_req;
  logic [31:0] exp_result, lit_val;
  string       lit_name;
  int          n_pass = 0;
  int          n_total = 0;

  // RISC-V M semantics computed with wide integer arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = 64'(a) * 64'(b); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("md_ready", 32'(md_ready), 32'(exp_ready));
      check("md_busy", 32'(md_busy), 32'(md_en_ex & ~exp_ready));
      if (exp_ready) check("md_result_model", md_result, exp_result);
      if (lit_req) check(lit_name, md_result, lit_val);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lit, input int unsigned hold, input string name);
    int unsigned lat;
    md_en_ex  = 1'b1;
    md_op_ex  = op;
    src_a_ex  = a;
    src_b_ex  = b;
    ready_mem = 1'b0;
    exp_ready = 1'b0;
    lat = is_special(op, a, b) ? 2 : 34;
    tick;                       // accept edge
    repeat (lat - 1) tick;      // now in the cycle md_ready must be high
    exp_ready  = 1'b1;
    exp_result = model(op, a, b);
    lit_req    = 1'b1;
    lit_val    = lit;
    lit_name   = name;
    for (int unsigned h = 0; h < hold; h++) begin
      tick;
      lit_req = 1'b0;
    end
    ready_mem = 1'b1;
    tick;                       // DONE -> IDLE, EX advances
    lit_req   = 1'b0;
    md_en_ex  = 1'b0;
    exp_ready = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int unsigned hold;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV] = '{
    '{MD_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0},
    '{MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0},
    '{MD_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0},
    '{MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0},
    '{MD_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 0},
    '{MD_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 0},
    '{MD_DIVU,   32'h0000_0007, 32'h0000_0002, 32'h0000_0003, 0},
    '{MD_REMU,   32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 0},
    '{MD_DIV,    32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 0},
    '{MD_REM,    32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 0},
    '{MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0},
    '{MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0},
    '{MD_DIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 0},
    '{MD_REMU,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 0},
    '{MD_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0},
    '{MD_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0},
    '{MD_MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 3},
    '{MD_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0},
    '{MD_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1},
    '{MD_MUL,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0},
    '{MD_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; md_en_ex = 1'b0; flush_E = 1'b0; ready_mem = 1'b1;
    md_op_ex = '0; src_a_ex = '0; src_b_ex = '0;
    check_en = 1'b0; exp_ready = 1'b0; lit_req = 1'b0;
    exp_result = '0; lit_val = '0; lit_name = "";

    tick;
    check_en = 1'b1;
    lit_req = 1'b1; lit_val = 32'd0; lit_name = "reset_result";
    tick;
    md_en_ex = 1'b1;            // busy must follow md_en_ex even in reset
    tick;
    lit_req = 1'b0; md_en_ex = 1'b0; reset_n = 1'b1;
    tick;

    for (int i = 0; i < NV; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold, $sformatf("vec%0d", i));

    // flush during CALC iteration 10
    md_en_ex = 1'b1; md_op_ex = MD_DIV; src_a_ex = 32'd100; src_b_ex = 32'd7; ready_mem = 1'b1;
    tick;
    repeat (10) tick;
    flush_E = 1'b1;
    tick;
    flush_E = 1'b0;
    run_op(MD_DIV, 32'd100, 32'd7, 32'd14, 0, "after_calc_flush");

    // flush with md_en_ex in IDLE: nothing may be accepted
    md_en_ex = 1'b1; md_op_ex = MD_MUL; src_a_ex = 32'd3; src_b_ex = 32'd5; flush_E = 1'b1;
    tick;
    flush_E = 1'b0;
    run_op(MD_REMU, 32'd100, 32'd7, 32'd2, 0, "after_idle_flush");

    // reset in the middle of CALC
    md_en_ex = 1'b1; md_op_ex = MD_MUL; src_a_ex = 32'd3; src_b_ex = 32'd5;
    tick;
    repeat (5) tick;
    reset_n = 1'b0; md_en_ex = 1'b0;
    tick;
    lit_req = 1'b1; lit_val = 32'd0; lit_name = "mid_calc_reset_result";
    reset_n = 1'b1;
    tick;
    lit_req = 1'b0;
    run_op(MD_MUL, 32'd3, 32'd5, 32'd15, 0, "after_reset");

    tick;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
